// File: rtl/meter_time_counter.sv
// Parking-meter countdown: button adds, held-switch presets, saturating COUNT, per-tick decrement.
// Optional display blink for low/expired time is compiled in when METER_BLINK_EN is defined.
module meter_time_counter #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1,
  parameter int WIDTH      = 16,
  parameter int MAX_COUNT  = 9999,
  parameter int ADD_U      = 60,
  parameter int ADD_L      = 120,
  parameter int ADD_R      = 180,
  parameter int ADD_D      = 300,
  parameter int PRESET0    = 10,
  parameter int PRESET1    = 205,
  parameter int LOW_THRESH = 180
) (
  input  logic             SYS_CLK,
  input  logic             RESET,
  input  logic             UP,
  input  logic             LEFT,
  input  logic             RIGHT,
  input  logic             DOWN,
  input  logic             SW0,
  input  logic             SW1,
  output logic [WIDTH-1:0] COUNT,
  output logic             EXPIRED,
  output logic             TICK,
  output logic             BLANK
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SUM_W = WIDTH + 3;

  typedef enum logic [1:0] {EMPTY, RUN, HOLD} state_t;

  state_t           state, state_next;
  logic [3:0]       btn_s1, btn_s2, btn_prev, btn_edge;
  logic [1:0]       sw_s1, sw_s2;
  logic [2:0]       sync_vld;
  logic [DIV_W-1:0] div, div_next;
  logic [WIDTH-1:0] count_next, add_sat;
  logic [SUM_W-1:0] add_sum;
  logic             hold_req, tick_int;

`ifdef METER_BLINK_EN
  localparam int HALF = DIV / 2;
  logic blink_q, blink_next;
`endif

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      sync_vld <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample its pre-edge input, so the chain shifts exactly one stage per clock.
      btn_s1   <= {DOWN, RIGHT, LEFT, UP};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      sw_s1    <= {SW1, SW0};
      sw_s2    <= sw_s1;
      sync_vld <= {sync_vld[1:0], 1'b1};
    end
  end

  // Edges stay masked until btn_prev holds a real post-reset sample, so a
  // button held through reset must go low and high again before it counts.
  assign btn_edge = btn_s2 & ~btn_prev & {4{sync_vld[2]}};
  assign hold_req = |sw_s2;
  assign tick_int = (state == RUN) && (div == DIV_W'(DIV - 1));

  assign add_sum = {3'b000, COUNT}
                 + (btn_edge[0] ? SUM_W'(ADD_U) : '0)
                 + (btn_edge[1] ? SUM_W'(ADD_L) : '0)
                 + (btn_edge[2] ? SUM_W'(ADD_R) : '0)
                 + (btn_edge[3] ? SUM_W'(ADD_D) : '0);
  assign add_sat = (add_sum > SUM_W'(MAX_COUNT)) ? WIDTH'(MAX_COUNT) : add_sum[WIDTH-1:0];

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    count_next = COUNT;
    state_next = state;
    if (hold_req) begin
      count_next = sw_s2[0] ? WIDTH'(PRESET0) : WIDTH'(PRESET1);
      state_next = HOLD;
    end else if (state == HOLD) begin
      state_next = (COUNT == '0) ? EMPTY : RUN;
    end else if (|btn_edge) begin
      count_next = add_sat;
      state_next = (add_sat == '0) ? EMPTY : RUN;
    end else if (tick_int && (COUNT != '0)) begin
      count_next = COUNT - WIDTH'(1);
      state_next = (COUNT == WIDTH'(1)) ? EMPTY : RUN;
    end
  end

  always_comb begin
    div_next = '0;
`ifdef METER_BLINK_EN
    blink_next = 1'b0;
`endif
    if (state == RUN) begin
      div_next = tick_int ? '0 : div + DIV_W'(1);
`ifdef METER_BLINK_EN
    end else if ((state == EMPTY) && (state_next == EMPTY)) begin
      // Expired: divider free-runs over half a period purely to pace the flash.
      div_next   = (div == DIV_W'(HALF - 1)) ? '0 : div + DIV_W'(1);
      blink_next = (div == DIV_W'(HALF - 1)) ? ~blink_q : blink_q;
`endif
    end
  end

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      state   <= EMPTY;
      COUNT   <= '0;
      div     <= '0;
`ifdef METER_BLINK_EN
      blink_q <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      COUNT   <= count_next;
      div     <= div_next;
`ifdef METER_BLINK_EN
      blink_q <= blink_next;
`endif
    end
  end

  assign EXPIRED = (COUNT == '0);
  assign TICK    = tick_int;

`ifdef METER_BLINK_EN
  assign BLANK = (state == EMPTY) ? blink_q
               : ((state == RUN) && (COUNT != '0) && (COUNT < WIDTH'(LOW_THRESH))
                  && (div >= DIV_W'(HALF)));
`else
  assign BLANK = 1'b0;
`endif

endmodule

// File: doc/meter_time_counter.md
# meter_time_counter

Parametrised countdown timer for the parking-meter datapath: accumulates paid time from four push-buttons, counts down once per tick, and supports two held-switch presets. Fully synchronous on SYS_CLK with an internal tick divider, in-block button synchronisers and rising-edge detectors, and saturating arithmetic. COUNT feeds the binary-to-BCD / seven-segment display path.

## Interface
Parameters:
- CLK_HZ, 100_000_000: SYS_CLK frequency.
- TICK_HZ, 1: decrement rate. CLK_HZ/TICK_HZ must be an integer ≥ 2.
- WIDTH, 16: COUNT width.
- MAX_COUNT, 9999: saturation ceiling. Must be < 2^WIDTH.
- ADD_U, 60 / ADD_L, 120 / ADD_R, 180 / ADD_D, 300: amount added per press of UP, LEFT, RIGHT, DOWN.
- PRESET0, 10 / PRESET1, 205: values forced while SW0 / SW1 are held.
- LOW_THRESH, 180: COUNT values below this (and > 0) count as low time. Used only by the blink feature.

Ports:
- SYS_CLK  in  1  system clock; every register updates on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- UP, LEFT, RIGHT, DOWN  in  1 each  raw push-buttons, asynchronous to SYS_CLK.
- SW0, SW1  in  1 each  raw preset switches, asynchronous to SYS_CLK.
- COUNT  out  WIDTH  remaining time.
- EXPIRED  out  1  high when COUNT == 0.
- TICK  out  1  one-cycle pulse at each divider terminal count.
- BLANK  out  1  display-blank request (see Configuration).

## Operation
- Every button and switch passes through a 2-flop synchroniser. Each button also has a registered previous value, and an edge is sync2 & ~prev. Exactly one add per press, however long the button is held.
- State machine: EMPTY (COUNT == 0), RUN (COUNT > 0, decrementing), HOLD (either synchronised switch high).
- Transitions:
  - EMPTY → RUN on any button edge.
  - RUN → EMPTY when a decrement reaches 0.
  - Any state → HOLD while a switch is high.
  - On leaving HOLD: go to RUN (or EMPTY if the preset is 0).
- Per-cycle priority:
  1. RESET.
  2. HOLD: COUNT = PRESET0 if SW0 is high, else PRESET1. SW0 wins when both are high. Button edges and ticks in HOLD are discarded.
  3. Button edges: COUNT = min(COUNT + sum of all edge amounts this cycle, MAX_COUNT). The sum is computed WIDTH+3 bits wide. A tick in the same cycle is discarded.
  4. TICK in RUN: COUNT = COUNT − 1. COUNT never wraps below 0.
- Tick divider: counts 0..CLK_HZ/TICK_HZ−1 and asserts TICK at the terminal value. It runs only in RUN. It is held at 0 in EMPTY and HOLD, so the first decrement after leaving EMPTY or HOLD comes a full period later.
- EXPIRED is a combinational compare of the registered COUNT.

## Timing
- Reset values: COUNT = 0, EXPIRED = 1, TICK = 0, BLANK = 0, divider = 0, state = EMPTY, synchronisers and previous-value registers = 0.
- RESET asserted mid-operation clears everything immediately. After release, the first edge is counted only if the button is sampled low and then high.
- Button latency: COUNT changes on the 3rd rising edge at which the button is sampled high (2 synchroniser stages plus the count register).
- Switch latency: HOLD takes effect, and COUNT takes the preset value, on the 3rd rising edge at which the switch is sampled high. Releasing the switch takes the same latency.
- TICK and the resulting decrement: TICK is high in cycle n, and COUNT shows the decremented value from cycle n+1.
- At MAX_COUNT, further adds leave COUNT unchanged and the decrement continues normally.

## Configuration
- METER_BLINK_EN defined:
  - 0 < COUNT < LOW_THRESH: BLANK is high for the second half of each tick period, giving a 50 % flash at TICK_HZ.
  - COUNT == 0: BLANK toggles every CLK_HZ/(2·TICK_HZ) cycles. The divider free-runs for this purpose only and produces no TICK.
  - HOLD: BLANK = 0.
- METER_BLINK_EN undefined: BLANK is tied to 0 and the blink logic is not synthesised. All other behaviour is identical.

## Test plan
Bench parameters: CLK_HZ = 10, TICK_HZ = 1, MAX_COUNT = 9999, METER_BLINK_EN defined.
- Reset, then press UP for 20 cycles → COUNT becomes 60 exactly once, on the 3rd edge after the press; after 10 further cycles COUNT = 59; EXPIRED = 0.
- LEFT, RIGHT and DOWN rise in the same cycle from COUNT = 9500 → COUNT = 9999 (saturated). With COUNT at 9999, another DOWN press leaves COUNT at 9999.
- COUNT = 2 in RUN → after 20 cycles COUNT = 0 and EXPIRED = 1; no further TICK; COUNT never wraps to 65535.
- Hold SW0 and SW1 together from COUNT = 500 → COUNT = 10 and stays frozen; an UP press during the hold is ignored. Release both → the first decrement (to 9) comes exactly 10 cycles after HOLD exits.
- Assert RESET mid-period with COUNT = 300 while UP is held → COUNT = 0 at once; after release no add occurs until UP goes low and then high again.
- COUNT = 100 (below LOW_THRESH) → BLANK is low for 5 cycles, then high for 5 cycles, in every tick period. At COUNT = 0, BLANK toggles every 5 cycles.
